mem_access_unit: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's control pulse (ctrl_valid) plus its memory controls: mem_ren, mem_wen, wmask, load_ctrl, the ALU result used as address, and src2 used as store data.
- Performs at most one load or store per instruction over an AXI4-lite-style master port.
- Returns one writeback pulse per accepted instruction: load data aligned and extended, or the ALU result passed through.

---
 rtl/mau_pkg.sv | 41 ++++
 rtl/mau_axi_if.sv | 35 +++
 rtl/mau_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared types and encodings for the memory-access stage.
// MAU_MISALIGN_CHECK_EN enables the misalignment predicate used at acceptance.
package mau_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] OKAY = 2'b00;

    // A load wins over a store when both are flagged; unknown load_ctrl sizes as a word.
    function automatic logic is_misaligned(input logic       ren,
                                           input logic       wen,
                                           input logic [2:0] load_ctrl,
                                           input logic [3:0] wmask,
                                           input logic [1:0] offset);
        logic result;
        result = 1'b0;
        if (ren) begin
            if (load_ctrl == LB || load_ctrl == LBU) result = 1'b0;
            else if (load_ctrl == LH || load_ctrl == LHU) result = offset[0];
            else result = (offset != 2'b00);
        end else if (wen) begin
            if (wmask == 4'b0011) result = offset[0];
            else if (wmask == 4'b1111) result = (offset != 2'b00);
        end
        return result;
    endfunction

endpackage

// File: rtl/mau_axi_if.sv
// AXI4-lite-style read/write channels between the memory-access stage and memory.
interface mau_axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_W     = 2
);
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [RESP_W-1:0]     rresp;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [RESP_W-1:0]     bresp;
    logic                  bvalid;
    logic                  bready;

    // Every channel transfers on a cycle where valid and ready are both high;
    // a raised valid holds its payload stable until that cycle.
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/mau_load_align.sv
// Extracts the addressed byte/halfword from a read word and extends it per load type.
module mau_load_align
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_ctrl,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        // A halfword at offset 3 only has its low byte inside the word.
        case (load_ctrl)
            LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LBU: result = {24'b0, byte_sel};
            LH:  result = (offset == 2'b11) ? {{24{byte_sel[7]}}, byte_sel}
                                            : {{16{half_sel[15]}}, half_sel};
            LHU: result = (offset == 2'b11) ? {24'b0, byte_sel} : {16'b0, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one load or store per accepted instruction, one writeback pulse back.
// Define MAU_MISALIGN_CHECK_EN to fault misaligned accesses without touching the bus.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_W     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_ren,
    input  logic                  in_mem_wen,
    input  logic [2:0]            in_load_ctrl,
    input  logic [3:0]            in_wmask,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  in_reg_wen,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_wb_data,
    output logic                  out_reg_wen,
    output logic                  out_fault,
    output state_t                dbg_state,
    mau_axi_if.master             bus
);
    state_t                state, state_n;
    logic [2:0]            load_ctrl_q;
    logic [3:0]            wmask_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic                  reg_wen_q, aw_done, w_done;
    logic                  accept, misaligned, aw_fire, w_fire, r_err, b_err;
    logic [31:0]           load_value;

    assign accept  = in_valid && in_ready;
    assign aw_fire = bus.awvalid && bus.awready;
    assign w_fire  = bus.wvalid && bus.wready;
    assign r_err   = (bus.rresp != RESP_W'(OKAY));
    assign b_err   = (bus.bresp != RESP_W'(OKAY));

`ifdef MAU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(in_mem_ren, in_mem_wen, in_load_ctrl, in_wmask,
                                      in_alu_result[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    mau_load_align u_align (
        .rdata     (bus.rdata),
        .offset    (addr_q[1:0]),
        .load_ctrl (load_ctrl_q),
        .result    (load_value)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) begin
                if (misaligned)      state_n = DONE;
                else if (in_mem_ren) state_n = RD_ADDR;
                else if (in_mem_wen) state_n = WR_REQ;
                else                 state_n = DONE;
            end
            RD_ADDR: if (bus.arready) state_n = RD_DATA;
            RD_DATA: if (bus.rvalid)  state_n = DONE;
            WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WR_RESP;
            WR_RESP: if (bus.bvalid)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        bus.arvalid = (state == RD_ADDR);
        bus.rready  = (state == RD_DATA);
        bus.awvalid = (state == WR_REQ) && !aw_done;
        bus.wvalid  = (state == WR_REQ) && !w_done;
        bus.bready  = (state == WR_RESP);
        dbg_state   = state;
    end

    assign bus.araddr = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.awaddr = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign bus.wstrb  = wmask_q << addr_q[1:0];
    assign bus.wdata  = wdata_q << {addr_q[1:0], 3'b000};

    // Request capture, per-channel write progress, and the writeback result.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_ctrl_q <= '0;
            wmask_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            reg_wen_q   <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            out_wb_data <= '0;
            out_reg_wen <= 1'b0;
            out_fault   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    load_ctrl_q <= in_load_ctrl;
                    wmask_q     <= in_wmask;
                    addr_q      <= in_alu_result;
                    wdata_q     <= in_wdata;
                    reg_wen_q   <= in_reg_wen;
                    aw_done     <= 1'b0;
                    w_done      <= 1'b0;
                    if (misaligned) begin
                        out_wb_data <= '0;
                        out_reg_wen <= 1'b0;
                        out_fault   <= 1'b1;
                    end else if (!in_mem_ren && !in_mem_wen) begin
                        out_wb_data <= in_alu_result;
                        out_reg_wen <= in_reg_wen;
                        out_fault   <= 1'b0;
                    end
                end
                WR_REQ: begin
                    aw_done <= aw_done || aw_fire;
                    w_done  <= w_done || w_fire;
                end
                RD_DATA: if (bus.rvalid) begin
                    out_wb_data <= r_err ? '0 : load_value;
                    out_reg_wen <= reg_wen_q && !r_err;
                    out_fault   <= r_err;
                end
                WR_RESP: if (bus.bvalid) begin
                    out_wb_data <= '0;
                    out_reg_wen <= reg_wen_q && !b_err;
                    out_fault   <= b_err;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cycle-exact bus slave driving and inline checks.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_mem_ren, in_mem_wen, in_reg_wen;
    logic [2:0]  in_load_ctrl;
    logic [3:0]  in_wmask;
    logic [31:0] in_alu_result, in_wdata;
    logic        out_valid, out_reg_wen, out_fault;
    logic [31:0] out_wb_data;
    state_t      dbg_state;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    mau_axi_if bus_if ();

    mem_access_unit dut (
        .clock (clock), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_mem_ren (in_mem_ren), .in_mem_wen (in_mem_wen),
        .in_load_ctrl (in_load_ctrl), .in_wmask (in_wmask),
        .in_alu_result (in_alu_result), .in_wdata (in_wdata), .in_reg_wen (in_reg_wen),
        .out_valid (out_valid), .out_wb_data (out_wb_data),
        .out_reg_wen (out_reg_wen), .out_fault (out_fault),
        .dbg_state (dbg_state), .bus (bus_if)
    );

    // Execute must never pulse in_valid while the stage is busy.
    always @(negedge clock) begin
        if (!reset && in_valid && !in_ready) begin
            $display("FAIL protocol: in_ready=%b while in_valid, required 1", in_ready);
            errors++;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic slave_idle();
        bus_if.arready = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0; bus_if.rresp = '0;
        bus_if.awready = 1'b0; bus_if.wready = 1'b0; bus_if.bvalid = 1'b0; bus_if.bresp = '0;
    endtask

    // Drives a one-cycle instruction pulse; returns at the start of cycle T+1.
    task automatic issue(input logic ren, input logic wen, input logic [2:0] ctrl,
                         input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wd, input logic rwen);
        in_valid = 1'b1; in_mem_ren = ren; in_mem_wen = wen; in_load_ctrl = ctrl;
        in_wmask = mask; in_alu_result = addr; in_wdata = wd; in_reg_wen = rwen;
        next_cycle();
        in_valid = 1'b0; in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_load_ctrl = '0;
        in_wmask = '0; in_alu_result = '0; in_wdata = '0; in_reg_wen = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] flags;
        reset = 1'b1; in_valid = 1'b0; in_mem_ren = 1'b0; in_mem_wen = 1'b0;
        in_load_ctrl = '0; in_wmask = '0; in_alu_result = '0; in_wdata = '0; in_reg_wen = 1'b0;
        slave_idle();
        next_cycle();
        next_cycle();
        @(negedge clock);
        flags = {in_ready, bus_if.arvalid, bus_if.rready, bus_if.awvalid, bus_if.wvalid,
                 bus_if.bready, out_valid, out_reg_wen, out_fault};
        checks++;
        if (flags !== 9'b100000000) begin
            $display("FAIL reset_flags: got %b required 100000000", flags); errors++;
        end
        checks++;
        if (out_wb_data !== 32'h0 || bus_if.araddr !== 32'h0 || bus_if.wstrb !== 4'h0) begin
            $display("FAIL reset_data: wb=%h araddr=%h wstrb=%b required all 0",
                     out_wb_data, bus_if.araddr, bus_if.wstrb); errors++;
        end
        checks++;
        if (dbg_state !== IDLE) begin
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); errors++;
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_non_mem();
        slave_idle();
        issue(1'b0, 1'b0, LW, 4'b0000, 32'h1234_5678, 32'h0, 1'b1);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h1234_5678 || out_reg_wen !== 1'b1
            || out_fault !== 1'b0) begin
            $display("FAIL non_mem_wb: valid=%b wb=%h rwen=%b fault=%b required 1 12345678 1 0",
                     out_valid, out_wb_data, out_reg_wen, out_fault); errors++;
        end
        checks++;
        if (bus_if.arvalid !== 1'b0 || bus_if.awvalid !== 1'b0 || bus_if.wvalid !== 1'b0) begin
            $display("FAIL non_mem_bus: arvalid=%b awvalid=%b wvalid=%b required 0 0 0",
                     bus_if.arvalid, bus_if.awvalid, bus_if.wvalid); errors++;
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL non_mem_after: valid=%b in_ready=%b required 0 1",
                     out_valid, in_ready); errors++;
        end
        next_cycle();
    endtask

    // Load with arready and rvalid already high: data comes back at T+3.
    task automatic test_load_imm(input string name, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] rd,
                                 input logic [31:0] exp_araddr, input logic [31:0] exp_wb);
        slave_idle();
        bus_if.arready = 1'b1; bus_if.rvalid = 1'b1; bus_if.rdata = rd;
        issue(1'b1, 1'b0, ctrl, 4'b0000, addr, 32'h0, 1'b1);
        @(negedge clock);
        checks++;
        if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== exp_araddr || bus_if.rready !== 1'b0) begin
            $display("FAIL %s_ar: arvalid=%b araddr=%h rready=%b required 1 %h 0",
                     name, bus_if.arvalid, bus_if.araddr, bus_if.rready, exp_araddr); errors++;
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus_if.arvalid !== 1'b0 || bus_if.rready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL %s_r: arvalid=%b rready=%b valid=%b required 0 1 0",
                     name, bus_if.arvalid, bus_if.rready, out_valid); errors++;
        end
        next_cycle();
        slave_idle();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== exp_wb || out_reg_wen !== 1'b1
            || out_fault !== 1'b0) begin
            $display("FAIL %s_wb: valid=%b wb=%h rwen=%b fault=%b required 1 %h 1 0",
                     name, out_valid, out_wb_data, out_reg_wen, out_fault, exp_wb); errors++;
        end
        next_cycle();
    endtask

    // Store with every slave ready up front: both channels complete in T+1.
    task automatic test_store_imm(input string name, input logic [3:0] mask,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                                  input logic [31:0] exp_awaddr);
        slave_idle();
        bus_if.awready = 1'b1; bus_if.wready = 1'b1; bus_if.bvalid = 1'b1;
        issue(1'b0, 1'b1, LW, mask, addr, wd, 1'b0);
        @(negedge clock);
        checks++;
        if (bus_if.awvalid !== 1'b1 || bus_if.wvalid !== 1'b1 || bus_if.wstrb !== exp_strb
            || bus_if.wdata !== exp_wdata || bus_if.awaddr !== exp_awaddr) begin
            $display("FAIL %s_req: awv=%b wv=%b wstrb=%b wdata=%h awaddr=%h required 1 1 %b %h %h",
                     name, bus_if.awvalid, bus_if.wvalid, bus_if.wstrb, bus_if.wdata,
                     bus_if.awaddr, exp_strb, exp_wdata, exp_awaddr); errors++;
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus_if.bready !== 1'b1 || bus_if.awvalid !== 1'b0 || bus_if.wvalid !== 1'b0) begin
            $display("FAIL %s_b: bready=%b awv=%b wv=%b required 1 0 0",
                     name, bus_if.bready, bus_if.awvalid, bus_if.wvalid); errors++;
        end
        next_cycle();
        slave_idle();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h0 || out_fault !== 1'b0) begin
            $display("FAIL %s_done: valid=%b wb=%h fault=%b required 1 0 0",
                     name, out_valid, out_wb_data, out_fault); errors++;
        end
        next_cycle();
    endtask

    task automatic test_store_split();
        slave_idle();
        issue(1'b0, 1'b1, LW, 4'b0011, 32'h8000_0002, 32'h0000_BEEF, 1'b1);
        bus_if.awready = 1'b1;
        @(negedge clock);
        checks++;
        if (bus_if.awvalid !== 1'b1 || bus_if.wvalid !== 1'b1 || bus_if.wstrb !== 4'b1100
            || bus_if.wdata !== 32'hBEEF_0000 || bus_if.awaddr !== 32'h8000_0000) begin
            $display("FAIL sh_req: awv=%b wv=%b wstrb=%b wdata=%h awaddr=%h required 1 1 1100 beef0000 80000000",
                     bus_if.awvalid, bus_if.wvalid, bus_if.wstrb, bus_if.wdata, bus_if.awaddr);
            errors++;
        end
        next_cycle();
        bus_if.awready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            if (c == 4) bus_if.wready = 1'b1;
            @(negedge clock);
            checks++;
            if (bus_if.awvalid !== 1'b0 || bus_if.wvalid !== 1'b1 || bus_if.bready !== 1'b0) begin
                $display("FAIL sh_wait_T%0d: awv=%b wv=%b bready=%b required 0 1 0",
                         c, bus_if.awvalid, bus_if.wvalid, bus_if.bready); errors++;
            end
            next_cycle();
        end
        bus_if.wready = 1'b0; bus_if.bvalid = 1'b1;
        @(negedge clock);
        checks++;
        if (bus_if.bready !== 1'b1 || bus_if.wvalid !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL sh_b: bready=%b wv=%b valid=%b required 1 0 0",
                     bus_if.bready, bus_if.wvalid, out_valid); errors++;
        end
        next_cycle();
        slave_idle();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h0 || out_reg_wen !== 1'b1
            || out_fault !== 1'b0) begin
            $display("FAIL sh_done: valid=%b wb=%h rwen=%b fault=%b required 1 0 1 0",
                     out_valid, out_wb_data, out_reg_wen, out_fault); errors++;
        end
        next_cycle();
    endtask

    task automatic test_load_error();
        slave_idle();
        issue(1'b1, 1'b0, LW, 4'b0000, 32'h1000_0004, 32'h0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) bus_if.arready = 1'b1;
            @(negedge clock);
            checks++;
            if (bus_if.arvalid !== 1'b1 || bus_if.araddr !== 32'h1000_0004) begin
                $display("FAIL lw_ar_hold_T%0d: arvalid=%b araddr=%h required 1 10000004",
                         c, bus_if.arvalid, bus_if.araddr); errors++;
            end
            next_cycle();
        end
        bus_if.arready = 1'b0; bus_if.rvalid = 1'b1; bus_if.rresp = 2'b10;
        bus_if.rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++;
        if (bus_if.rready !== 1'b1) begin
            $display("FAIL lw_rready: got %b required 1", bus_if.rready); errors++;
        end
        next_cycle();
        slave_idle();
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_reg_wen !== 1'b0
            || out_wb_data !== 32'h0) begin
            $display("FAIL lw_err: valid=%b fault=%b rwen=%b wb=%h required 1 1 0 0",
                     out_valid, out_fault, out_reg_wen, out_wb_data); errors++;
        end
        next_cycle();
    endtask

    task automatic test_ren_wen_both();
        int aw_seen;
        aw_seen = 0;
        slave_idle();
        bus_if.arready = 1'b1; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h1122_3344;
        bus_if.awready = 1'b1; bus_if.wready = 1'b1;
        issue(1'b1, 1'b1, LW, 4'b1111, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (bus_if.awvalid || bus_if.wvalid) aw_seen++;
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_wb_data !== 32'h1122_3344 || aw_seen != 0) begin
                    $display("FAIL both_load: valid=%b wb=%h write_cycles=%0d required 1 11223344 0",
                             out_valid, out_wb_data, aw_seen); errors++;
                end
            end
            next_cycle();
        end
        slave_idle();
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        slave_idle();
        bus_if.arready = 1'b1;
        issue(1'b1, 1'b0, LW, 4'b0000, 32'h0000_0020, 32'h0, 1'b1);
        next_cycle();
        bus_if.arready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus_if.rready !== 1'b1) begin
            $display("FAIL rst_mid_rd: rready=%b required 1", bus_if.rready); errors++;
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus_if.rready !== 1'b0 || in_ready !== 1'b1 || bus_if.arvalid !== 1'b0
            || dbg_state !== IDLE) begin
            $display("FAIL rst_mid_idle: rready=%b in_ready=%b arvalid=%b state=%0d required 0 1 0 0",
                     bus_if.rready, in_ready, bus_if.arvalid, dbg_state); errors++;
        end
        for (int c = 0; c < 5; c++) begin
            if (out_valid) pulses++;
            next_cycle();
            @(negedge clock);
        end
        checks++;
        if (pulses != 0) begin
            $display("FAIL rst_mid_no_wb: out_valid pulses=%0d required 0", pulses); errors++;
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        slave_idle();
        issue(1'b0, 1'b0, LW, 4'b0000, 32'hAAAA_0001, 32'h0, 1'b1);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'hAAAA_0001) begin
            $display("FAIL b2b_first: valid=%b wb=%h required 1 aaaa0001", out_valid, out_wb_data);
            errors++;
        end
        next_cycle();
        issue(1'b0, 1'b0, LW, 4'b0000, 32'h5555_0002, 32'h0, 1'b0);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_wb_data !== 32'h5555_0002 || out_reg_wen !== 1'b0) begin
            $display("FAIL b2b_second: valid=%b wb=%h rwen=%b required 1 55550002 0",
                     out_valid, out_wb_data, out_reg_wen); errors++;
        end
        next_cycle();
    endtask

`ifdef MAU_MISALIGN_CHECK_EN
    task automatic test_misalign(input string name, input logic ren, input logic wen,
                                 input logic [2:0] ctrl, input logic [3:0] mask,
                                 input logic [31:0] addr);
        slave_idle();
        bus_if.awready = 1'b1; bus_if.wready = 1'b1; bus_if.arready = 1'b1;
        issue(ren, wen, ctrl, mask, addr, 32'h1234_5678, 1'b1);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_reg_wen !== 1'b0
            || bus_if.awvalid !== 1'b0 || bus_if.arvalid !== 1'b0) begin
            $display("FAIL %s: valid=%b fault=%b rwen=%b awv=%b arv=%b required 1 1 0 0 0",
                     name, out_valid, out_fault, out_reg_wen, bus_if.awvalid, bus_if.arvalid);
            errors++;
        end
        next_cycle();
        slave_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_non_mem();
        test_load_imm("lb", LB, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80);
        test_load_imm("lbu", LBU, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080);
        test_load_imm("lh2", LH, 32'h8000_0002, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_80FF);
        test_load_imm("lhu0", LHU, 32'h4000_0000, 32'h1234_8001, 32'h4000_0000, 32'h0000_8001);
        test_load_imm("lb1", LB, 32'h4000_0001, 32'h1234_7F01, 32'h4000_0000, 32'h0000_007F);
        test_load_imm("lw", LW, 32'h4000_0008, 32'hCAFE_F00D, 32'h4000_0008, 32'hCAFE_F00D);
        test_load_imm("ldx", 3'b111, 32'h4000_000C, 32'h8765_4321, 32'h4000_000C, 32'h8765_4321);
        test_store_split();
        test_store_imm("sb1", 4'b0001, 32'h0000_0101, 32'h0000_00AB, 4'b0010, 32'h0000_AB00,
                       32'h0000_0100);
        test_store_imm("sw", 4'b1111, 32'h0000_0200, 32'h0102_0304, 4'b1111, 32'h0102_0304,
                       32'h0000_0200);
`ifndef MAU_MISALIGN_CHECK_EN
        test_store_imm("sh3", 4'b0011, 32'h8000_0003, 32'h0000_BEEF, 4'b1000, 32'hEF00_0000,
                       32'h8000_0000);
        test_load_imm("lh3", LH, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80);
        test_load_imm("lhu3", LHU, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080);
`else
        test_misalign("sw_mis", 1'b0, 1'b1, LW, 4'b1111, 32'h8000_0001);
        test_misalign("lh_mis", 1'b1, 1'b0, LH, 4'b0000, 32'h8000_0003);
`endif
        test_load_error();
        test_ren_wen_both();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
